// File: rtl/mips_pc_pkg.sv
// Shared types and defaults for the PC sequencer and its target calculator.
package mips_pc_pkg;

    typedef enum logic [1:0] {
        ACT_INC      = 2'd0,
        ACT_BRANCH   = 2'd1,
        ACT_JUMP     = 2'd2,
        ACT_REGISTER = 2'd3
    } action_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

endpackage

// File: rtl/mips_datapath_pc_target.sv
// Combinational redirect target and jr/jalr misalignment detection.
module mips_datapath_pc_target
    import mips_pc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  action_t          action,
    input  logic [WIDTH-1:0] pcEx,
    input  logic [WIDTH-1:0] branchOffset,
    input  logic [25:0]      jumpIndex,
    input  logic [WIDTH-1:0] registerTarget,
    output logic [WIDTH-1:0] target,
    output logic             misaligned
);

    // Select the target for the resolved action; Inc has no target of its own.
    always_comb begin
        target     = pcEx;
        misaligned = 1'b0;
        case (action)
            ACT_BRANCH: target = pcEx + (branchOffset << 2);
            ACT_JUMP:   target[27:0] = {jumpIndex, 2'b00};
            ACT_REGISTER: begin
                target     = {registerTarget[WIDTH-1:2], 2'b00};
                misaligned = |registerTarget[1:0];
            end
            default: target = pcEx;
        endcase
    end

endmodule

// File: rtl/mips_datapath_pc_sequencer.sv
// Fetch PC register with redirect acceptance and wrong-path flush window.
module mips_datapath_pc_sequencer
    import mips_pc_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_PC    = WIDTH'(RESET_PC_DEFAULT),
    parameter int               FLUSH_DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             actionValid,
    input  action_t          action,
    input  logic [WIDTH-1:0] pcEx,
    input  logic [WIDTH-1:0] branchOffset,
    input  logic [25:0]      jumpIndex,
    input  logic [WIDTH-1:0] registerTarget,
    output logic [WIDTH-1:0] pc,
    output logic             flush,
    output logic             redirect,
    output logic             addrError
);

    state_t           state;
    logic [2:0]       left;
    logic [WIDTH-1:0] target;
    logic             misaligned;

    mips_datapath_pc_target #(.WIDTH(WIDTH)) u_target (
        .action         (action),
        .pcEx           (pcEx),
        .branchOffset   (branchOffset),
        .jumpIndex      (jumpIndex),
        .registerTarget (registerTarget),
        .target         (target),
        .misaligned     (misaligned)
    );

    // PC/state/flush sequencing; redirect and addrError are single-cycle pulses
    // that clear even under stall, while pc, state, left and flush hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc        <= RESET_PC;
            state     <= ST_RUN;
            left      <= 3'd0;
            flush     <= 1'b0;
            redirect  <= 1'b0;
            addrError <= 1'b0;
        end else begin
            redirect  <= 1'b0;
            addrError <= 1'b0;
            if (!stall) begin
                case (state)
                    ST_RUN: begin
                        if (actionValid && action != ACT_INC) begin
                            pc        <= target;
                            state     <= ST_FLUSH;
                            left      <= 3'(FLUSH_DEPTH - 1);
                            flush     <= 1'b1;
                            redirect  <= 1'b1;
                            addrError <= misaligned;
                        end else begin
                            pc <= pc + WIDTH'(4);
                        end
                    end
                    ST_FLUSH: begin
                        // Younger instructions are wrong-path: actionValid ignored here.
                        pc <= pc + WIDTH'(4);
                        if (left == 3'd0) begin
                            state <= ST_RUN;
                            flush <= 1'b0;
                        end else begin
                            left <= left - 3'd1;
                        end
                    end
                    default: state <= ST_RUN;
                endcase
            end
        end
    end

endmodule
